// File: rtl/prog_encoder.sv
// prog_encoder: sequential MIPS instruction encoder and program loader.
// Accepts one mnemonic-level request per valid/ready handshake. It encodes the
// request into one or two 32-bit MIPS words and writes them to instruction
// memory at an auto-incrementing word address. LI expands into LUI + ORI.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_op              mnemonic code (0..26 legal, 27..31 illegal)
//   req_rs/rt/rd/shamt  register and shift fields
//   req_imm             immediate or jump target
//   addr_load(_val)     load the write pointer (only honoured while idle)
//   imem_we/addr/wdata  registered instruction-memory write port
//   err_illegal         one-cycle pulse after an illegal op is accepted
//   wrapped             sticky flag, the pointer wrapped past its maximum
//   word_count          words written since reset, saturating at 0xFFFF
module prog_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [31:0]       req_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_load_val,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_illegal,
  output logic              wrapped,
  output logic [15:0]       word_count
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_NOR   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_JR    = 5'd11;
  localparam logic [4:0] OP_ANDI  = 5'd12;
  localparam logic [4:0] OP_ORI   = 5'd13;
  localparam logic [4:0] OP_SLTI  = 5'd14;
  localparam logic [4:0] OP_ADDI  = 5'd15;
  localparam logic [4:0] OP_ADDIU = 5'd16;
  localparam logic [4:0] OP_BEQ   = 5'd17;
  localparam logic [4:0] OP_BNE   = 5'd18;
  localparam logic [4:0] OP_BGTZ  = 5'd19;
  localparam logic [4:0] OP_BGEZ  = 5'd20;
  localparam logic [4:0] OP_LW    = 5'd21;
  localparam logic [4:0] OP_SW    = 5'd22;
  localparam logic [4:0] OP_LUI   = 5'd23;
  localparam logic [4:0] OP_JAL   = 5'd24;
  localparam logic [4:0] OP_LI    = 5'd25;
  localparam logic [4:0] OP_NOP   = 5'd26;

  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              li_pend;      // the word on the bus now is LI word 1
  logic [31:0]       li_lo_word;   // LI word 2, captured at acceptance
  logic              op_legal;
  logic              accept;
  logic              issue;
  logic [31:0]       issue_word;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // First (or only) word of a legal request; anything unmatched encodes as NOP.
  function automatic logic [31:0] encode_first(input logic [4:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [4:0] sh, input logic [31:0] imm);
    logic [31:0] w;
    case (op)
      OP_ADD:   w = r_word(rs, rt, rd, 5'd0, 6'b100000);
      OP_ADDU:  w = r_word(rs, rt, rd, 5'd0, 6'b100001);
      OP_SUB:   w = r_word(rs, rt, rd, 5'd0, 6'b100010);
      OP_SUBU:  w = r_word(rs, rt, rd, 5'd0, 6'b100011);
      OP_AND:   w = r_word(rs, rt, rd, 5'd0, 6'b100100);
      OP_OR:    w = r_word(rs, rt, rd, 5'd0, 6'b100101);
      OP_NOR:   w = r_word(rs, rt, rd, 5'd0, 6'b100111);
      OP_SLT:   w = r_word(rs, rt, rd, 5'd0, 6'b101010);
      OP_SLL:   w = r_word(5'd0, rt, rd, sh, 6'b000000);
      OP_SRL:   w = r_word(5'd0, rt, rd, sh, 6'b000010);
      OP_SRA:   w = r_word(5'd0, rt, rd, sh, 6'b000011);
      OP_JR:    w = r_word(rs, 5'd0, 5'd0, 5'd0, 6'b001000);
      OP_ANDI:  w = i_word(6'b001100, rs, rt, imm[15:0]);
      OP_ORI:   w = i_word(6'b001101, rs, rt, imm[15:0]);
      OP_SLTI:  w = i_word(6'b001010, rs, rt, imm[15:0]);
      OP_ADDI:  w = i_word(6'b001000, rs, rt, imm[15:0]);
      OP_ADDIU: w = i_word(6'b001001, rs, rt, imm[15:0]);
      OP_BEQ:   w = i_word(6'b000100, rs, rt, imm[15:0]);
      OP_BNE:   w = i_word(6'b000101, rs, rt, imm[15:0]);
      OP_BGTZ:  w = i_word(6'b000111, rs, 5'd0, imm[15:0]);
      OP_BGEZ:  w = i_word(6'b000001, rs, 5'd1, imm[15:0]);
      OP_LW:    w = i_word(6'b100011, rs, rt, imm[15:0]);
      OP_SW:    w = i_word(6'b101011, rs, rt, imm[15:0]);
      OP_LUI:   w = i_word(6'b001111, 5'd0, rt, imm[15:0]);
      OP_JAL:   w = {6'b000011, imm[25:0]};
      OP_LI:    w = i_word(6'b001111, 5'd0, rt, imm[31:16]);
      default:  w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign op_legal  = (req_op <= OP_NOP);
  assign req_ready = (state == IDLE) && !addr_load;
  assign accept    = req_valid && req_ready;

  // Select the word (if any) to be presented on the write port next cycle.
  always_comb begin
    issue      = 1'b0;
    issue_word = 32'h0000_0000;
    case (state)
      IDLE: begin
        if (accept && op_legal) begin
          issue      = 1'b1;
          issue_word = encode_first(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm);
        end
      end
      WR1: begin
        if (li_pend) begin
          issue      = 1'b1;
          issue_word = li_lo_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      li_pend     <= 1'b0;
      li_lo_word  <= 32'h0000_0000;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'h0000_0000;
      err_illegal <= 1'b0;
      wrapped     <= 1'b0;
      word_count  <= 16'h0000;
    end else begin
      err_illegal <= 1'b0;
      imem_we     <= issue;

      // Pointer, wrap flag and word count all advance with each word issued.
      if (issue) begin
        imem_addr  <= ptr;
        imem_wdata <= issue_word;
        ptr        <= ptr + 1'b1;
        if (&ptr)
          wrapped <= 1'b1;
        if (word_count != 16'hFFFF)
          word_count <= word_count + 16'd1;
      end

      case (state)
        IDLE: begin
          if (addr_load) begin
            ptr <= addr_load_val;
          end else if (req_valid) begin
            if (op_legal) begin
              li_pend    <= (req_op == OP_LI);
              li_lo_word <= i_word(6'b001101, req_rt, req_rt, req_imm[15:0]);
              state      <= WR1;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        WR1: begin
          state   <= li_pend ? WR2 : IDLE;
          li_pend <= 1'b0;
        end
        WR2: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_encoder.sv
// Bench for prog_encoder: directed cases with literal expectations, then
// randomized traffic compared every cycle against a word-queue model.
module tb_prog_encoder;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [4:0]        req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [31:0]       req_imm = '0;
  logic              addr_load = 1'b0;
  logic [ADDR_W-1:0] addr_load_val = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_illegal;
  logic              wrapped;
  logic [15:0]       word_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  prog_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm),
    .addr_load(addr_load), .addr_load_val(addr_load_val),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err_illegal(err_illegal), .wrapped(wrapped), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int fn_tab[12]  = '{32, 33, 34, 35, 36, 37, 39, 42, 0, 2, 3, 8};
  int iop_tab[12] = '{12, 13, 10, 8, 9, 4, 5, 7, 1, 35, 43, 15};

  function automatic logic [31:0] rfmt(longint rs, longint rt, longint rd, longint sh, longint fn);
    longint v;
    v = rs * (2**21) + rt * (2**16) + rd * (2**11) + sh * (2**6) + fn;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ifmt(longint op, longint rs, longint rt, longint imm16);
    longint v;
    v = op * (2**26) + rs * (2**21) + rt * (2**16) + imm16;
    return v[31:0];
  endfunction

  logic [31:0] q[$];
  int          m_ptr;
  bit          m_we, m_err, m_wrapped;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  int          m_count;

  task automatic model_push(input int op, input int rs, input int rt, input int rd,
                            input int sh, input longint imm);
    longint lo, hi;
    int r, s;
    lo = imm % 65536;
    hi = imm / 65536;
    if (op <= 7)       q.push_back(rfmt(rs, rt, rd, 0, fn_tab[op]));
    else if (op <= 10) q.push_back(rfmt(0, rt, rd, sh, fn_tab[op]));
    else if (op == 11) q.push_back(rfmt(rs, 0, 0, 0, fn_tab[op]));
    else if (op <= 23) begin
      r = rt; s = rs;
      if (op == 19) r = 0;
      if (op == 20) r = 1;
      if (op == 23) s = 0;
      q.push_back(ifmt(iop_tab[op-12], s, r, lo));
    end
    else if (op == 24) q.push_back(ifmt(3, 0, 0, 0) + 32'(imm % (2**26)));
    else if (op == 25) begin
      q.push_back(ifmt(15, 0, rt, hi));
      q.push_back(ifmt(13, rt, rt, lo));
    end
    else q.push_back(32'h0);
  endtask

  // Block is idle exactly when no word is on the write port.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ptr = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_err = 0; m_wrapped = 0; m_count = 0;
    end else begin
      m_err = 0;
      if (!m_we) begin
        if (addr_load) m_ptr = int'(addr_load_val);
        else if (req_valid) begin
          if (req_op > 26) m_err = 1;
          else model_push(int'(req_op), int'(req_rs), int'(req_rt), int'(req_rd),
                          int'(req_shamt), longint'(req_imm));
        end
      end
      if (q.size() > 0) begin
        m_wdata = q.pop_front();
        m_we    = 1;
        m_addr  = m_ptr[7:0];
        if (m_ptr == 255) m_wrapped = 1;
        m_ptr = (m_ptr + 1) % 256;
        if (m_count < 65535) m_count++;
      end else begin
        m_we = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_we", imem_we, m_we);
      if (m_we) begin
        chk("m_addr", imem_addr, m_addr);
        chk("m_wdata", imem_wdata, m_wdata);
      end
      chk("m_err", err_illegal, m_err);
      chk("m_wrapped", wrapped, m_wrapped);
      chk("m_count", word_count, m_count);
      chk("m_ready", req_ready, (!m_we && !addr_load));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 0; addr_load = 0;
    @(negedge clk);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", word_count, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_ready", req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Returns just after the accepting edge (inside cycle N+1).
  task automatic issue(input int op, input int rs, input int rt, input int rd,
                       input int sh, input logic [31:0] imm);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1; req_op = 5'(op); req_rs = 5'(rs); req_rt = 5'(rt);
    req_rd = 5'(rd); req_shamt = 5'(sh); req_imm = imm;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) chk("issue_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic lit_write(input string name, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    chk({name, "_we"}, imem_we, 1);
    chk({name, "_addr"}, imem_addr, addr);
    chk({name, "_wdata"}, imem_wdata, data);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // ADD with shamt ignored
    do_reset();
    issue(0, 1, 2, 3, 7, 32'h0);
    lit_write("add", 32'h00, 32'h0022_1820);
    chk("add_count", word_count, 1);

    // ADDI then BGEZ, ready low for exactly one cycle after each accept
    do_reset();
    issue(15, 1, 2, 0, 0, 32'h0000_FFFF);
    lit_write("addi", 32'h00, 32'h2022_FFFF);
    chk("addi_ready_lo", req_ready, 0);
    @(negedge clk);
    chk("addi_ready_hi", req_ready, 1);
    issue(20, 4, 9, 0, 0, 32'h10);
    lit_write("bgez", 32'h01, 32'h0481_0010);
    chk("bgez_ready_lo", req_ready, 0);
    @(negedge clk);
    chk("bgez_ready_hi", req_ready, 1);

    // LI expands to LUI + ORI
    do_reset();
    issue(25, 0, 5, 0, 0, 32'h1234_5678);
    lit_write("li_w1", 32'h00, 32'h3C05_1234);
    chk("li_ready_n1", req_ready, 0);
    lit_write("li_w2", 32'h01, 32'h34A5_5678);
    chk("li_ready_n2", req_ready, 0);
    @(negedge clk);
    chk("li_ready_n3", req_ready, 1);
    chk("li_count", word_count, 2);

    // addr_load wins over a request, then JAL at the top address wraps
    do_reset();
    @(posedge clk); #1;
    addr_load = 1; addr_load_val = 8'hFF;
    req_valid = 1; req_op = 5'd24; req_rs = 0; req_rt = 0; req_imm = 32'h40;
    @(negedge clk);
    chk("load_ready", req_ready, 0);
    @(posedge clk); #1;
    addr_load = 0;
    @(negedge clk);
    chk("post_load_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    lit_write("jal", 32'hFF, 32'h0C00_0040);
    chk("jal_wrapped", wrapped, 1);

    // illegal op: error pulse, no write, pointer unchanged
    issue(29, 1, 1, 1, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("ill_err", err_illegal, 1);
    chk("ill_we", imem_we, 0);
    chk("ill_ready", req_ready, 1);
    @(negedge clk);
    chk("ill_err_gone", err_illegal, 0);
    issue(26, 3, 3, 3, 3, 32'hABCD_EF01);
    lit_write("nop", 32'h00, 32'h0000_0000);
    chk("nop_wrapped", wrapped, 1);

    // reset during LI word 1 discards word 2
    do_reset();
    issue(25, 0, 5, 0, 0, 32'h1234_5678);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", imem_we, 0);
    chk("rst_mid_addr", imem_addr, 0);
    chk("rst_mid_count", word_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_we", imem_we, 0);
    chk("rst_rel_ready", req_ready, 1);
    chk("rst_rel_count", word_count, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 599) != 0);
      req_valid = ($urandom_range(0, 9) < 7);
      req_op    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(27, 31))
                                               : 5'($urandom_range(0, 26));
      req_rs    = 5'($urandom); req_rt = 5'($urandom);
      req_rd    = 5'($urandom); req_shamt = 5'($urandom);
      req_imm   = $urandom;
      addr_load = ($urandom_range(0, 15) == 0);
      addr_load_val = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1; req_valid = 0; addr_load = 0;
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
